// File: rtl/mdu_sequencer.sv
// Multi-cycle RISC-V M-extension sequencer: radix-4 shift-add multiply, restoring divide, sign fix-up.
// Define MDU_DIV_EN to build the divide datapath; without it DIV/DIVU/REM/REMU complete in two cycles with err=1.
// Handshake: a request is taken on any rising edge with req_valid=1, kill=0 and the FSM in IDLE or DONE;
// done is a one-cycle pulse in DONE and result stays stable until the next FIX cycle.
module mdu_sequencer (
    input  logic        clk_core,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        kill,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t      state, state_nx;
    logic        accept;
    logic [4:0]  cnt;
    logic [2:0]  op_q;
    logic        sign_a, sign_b;
    logic [31:0] opd;
    logic [63:0] acc;

    logic        sa_c, sb_c, b_zero;
    logic [31:0] a_mag, b_mag;
    logic [33:0] pp, mul_sum;
    logic [63:0] prod_fix;
    logic [31:0] fix_res;

    // Operand signs only matter for the signed flavours; magnitudes feed the unsigned core.
    always_comb begin
        sa_c = 1'b0;
        sb_c = 1'b0;
        if (req_op[2]) begin
            sa_c = ~req_op[0] & req_a[31];
            sb_c = ~req_op[0] & req_b[31];
        end else begin
            sa_c = (req_op == 3'd1 || req_op == 3'd2) & req_a[31];
            sb_c = (req_op == 3'd1) & req_b[31];
        end
        a_mag  = sa_c ? -req_a : req_a;
        b_mag  = sb_c ? -req_b : req_b;
        b_zero = (req_b == 32'd0);
    end

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (req_valid && !kill) begin
                    accept = 1'b1;
                    if (!req_op[2])
                        state_nx = MUL;
                    else begin
`ifdef MDU_DIV_EN
                        state_nx = b_zero ? FIX : DIV;
`else
                        state_nx = FIX;
`endif
                    end
                end
            end
            MUL: if (cnt == 5'd15) state_nx = FIX;
`ifdef MDU_DIV_EN
            DIV: if (cnt == 5'd31) state_nx = FIX;
`else
            DIV: state_nx = IDLE;
`endif
            FIX:     state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        if (kill) state_nx = IDLE;
    end

    assign busy = (state == MUL) || (state == DIV) || (state == FIX);
    assign done = (state == DONE);

    // Radix-4 step: add 0/1/2/3 x multiplicand to the high word, shift the product right by two.
    always_comb begin
        case (acc[1:0])
            2'd0:    pp = 34'd0;
            2'd1:    pp = {2'b00, opd};
            2'd2:    pp = {1'b0, opd, 1'b0};
            default: pp = {2'b00, opd} + {1'b0, opd, 1'b0};
        endcase
        mul_sum  = {2'b00, acc[63:32]} + pp;
        prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    end

`ifdef MDU_DIV_EN
    // Divide reuses acc as {remainder, dividend/quotient}.
    logic [32:0] div_diff;
    logic [31:0] q_fix, r_fix;
    always_comb begin
        div_diff = {acc[63:32], acc[31]} - {1'b0, opd};
        q_fix    = (sign_a ^ sign_b) ? -acc[31:0] : acc[31:0];
        r_fix    = sign_a ? -acc[63:32] : acc[63:32];
    end
`endif

    always_comb begin
        case (op_q)
            3'd0:       fix_res = prod_fix[31:0];
            3'd1, 3'd2,
            3'd3:       fix_res = prod_fix[63:32];
`ifdef MDU_DIV_EN
            3'd4, 3'd5: fix_res = q_fix;
            default:    fix_res = r_fix;
`else
            default:    fix_res = 32'd0;
`endif
        endcase
    end

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= 5'd0;
            op_q   <= 3'd0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            opd    <= 32'd0;
            acc    <= 64'd0;
            result <= 32'd0;
        end else if (accept) begin
            cnt  <= 5'd0;
            op_q <= req_op;
            if (!req_op[2]) begin
                sign_a <= sa_c;
                sign_b <= sb_c;
                opd    <= a_mag;
                acc    <= {32'd0, b_mag};
            end else if (b_zero) begin
                // Divide by zero: raw all-ones quotient, remainder is the untouched dividend.
                sign_a <= 1'b0;
                sign_b <= 1'b0;
                opd    <= 32'd0;
                acc    <= {req_a, 32'hFFFF_FFFF};
            end else begin
                sign_a <= sa_c;
                sign_b <= sb_c;
                opd    <= b_mag;
                acc    <= {32'd0, a_mag};
            end
        end else begin
            case (state)
                MUL: begin
                    acc <= {mul_sum, acc[31:2]};
                    cnt <= cnt + 5'd1;
                end
`ifdef MDU_DIV_EN
                DIV: begin
                    if (!div_diff[32]) acc <= {div_diff[31:0], acc[30:0], 1'b1};
                    else               acc <= {acc[62:0], 1'b0};
                    cnt <= cnt + 5'd1;
                end
`endif
                FIX: if (!kill) result <= fix_res;
                default: ;
            endcase
        end
    end

`ifdef MDU_DIV_EN
    assign err = 1'b0;
`else
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n)                  err <= 1'b0;
        else if (state == FIX && !kill) err <= op_q[2];
    end
`endif

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer; divide vectors are selected by MDU_DIV_EN.
module tb_mdu_sequencer;

    logic        clk_core = 1'b0;
    logic        reset_n  = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op   = 3'd0;
    logic [31:0] req_a    = 32'd0;
    logic [31:0] req_b    = 32'd0;
    logic        kill     = 1'b0;
    logic        busy, done, err;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_sequencer dut (
        .clk_core  (clk_core),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .kill      (kill),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .err       (err)
    );

    always #5 clk_core = ~clk_core;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Latency counts the cycle after the accept edge as 1; the done cycle number is reported.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input logic exp_err);
        int lat;
        @(negedge clk_core);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk_core);
        #1;
        req_valid = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk_core);
            #1;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_core);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk_core);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_res", result, 32'd0);
        #10 reset_n = 1'b1;

        run_op("mulh_neg",   3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 18, 1'b0);
        run_op("mulhu",      3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 18, 1'b0);
        run_op("mul_neg",    3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 18, 1'b0);
        run_op("mulh_min",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 18, 1'b0);
        run_op("mulhsu_min", 3'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 18, 1'b0);
        run_op("mulhsu_m1",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18, 1'b0);
        run_op("mul_big",    3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 18, 1'b0);

        // done is a single-cycle pulse and result holds afterwards
        @(posedge clk_core);
        #1;
        check("pulse_done", {31'd0, done}, 32'd0);
        check("pulse_busy", {31'd0, busy}, 32'd0);
        check("pulse_hold", result, 32'h0000_0001);

        // kill on the 10th MUL cycle, with a request on the same edge that must be ignored
        start_op(3'd0, 32'd7, 32'd9);
        repeat (9) @(posedge clk_core);
        #1;
        kill      = 1'b1;
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 32'd1;
        req_b     = 32'd1;
        @(posedge clk_core);
        #1;
        kill      = 1'b0;
        req_valid = 1'b0;
        check("kill_busy", {31'd0, busy}, 32'd0);
        check("kill_done", {31'd0, done}, 32'd0);
        check("kill_res", result, 32'h0000_0001);
        run_op("mul_after_kill", 3'd0, 32'd3, 32'd5, 32'h0000_000F, 18, 1'b0);

        // kill during DONE leaves the pulse visible that cycle
        kill = 1'b1;
        #1;
        check("kill_in_done", {31'd0, done}, 32'd1);
        @(posedge clk_core);
        #1;
        kill = 1'b0;
        check("kill_after_done", {31'd0, done}, 32'd0);

`ifdef MDU_DIV_EN
        run_op("div_neg",   3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, 1'b0);
        run_op("rem_neg",   3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, 1'b0);
        run_op("divu_zero", 3'd5, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 2, 1'b0);
        run_op("remu_zero", 3'd7, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 2, 1'b0);
        run_op("div_zero",  3'd4, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 2, 1'b0);
        run_op("rem_zero",  3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 2, 1'b0);
        run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 1'b0);
        run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, 1'b0);
        run_op("divu",      3'd5, 32'd100, 32'd7, 32'h0000_000E, 34, 1'b0);
        run_op("remu",      3'd7, 32'd100, 32'd7, 32'h0000_0002, 34, 1'b0);
        run_op("div_nb",    3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 1'b0);
        run_op("rem_nb",    3'd6, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 34, 1'b0);
        // reset on the 20th DIV cycle
        start_op(3'd5, 32'd100, 32'd7);
        repeat (19) @(posedge clk_core);
`else
        run_op("nodiv_div", 3'd4, 32'd10, 32'd2, 32'h0000_0000, 2, 1'b1);
        run_op("nodiv_mul", 3'd0, 32'd3, 32'd5, 32'h0000_000F, 18, 1'b0);
        run_op("nodiv_rem", 3'd7, 32'd10, 32'd3, 32'h0000_0000, 2, 1'b1);
        run_op("nodiv_mul2", 3'd0, 32'd6, 32'd7, 32'h0000_002A, 18, 1'b0);
        // reset on the 10th MUL cycle
        start_op(3'd0, 32'd100, 32'd7);
        repeat (9) @(posedge clk_core);
`endif
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_err", {31'd0, err}, 32'd0);
        check("arst_res", result, 32'd0);
        @(posedge clk_core);
        #1;
        reset_n = 1'b1;
        run_op("after_reset", 3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 18, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
